// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: round-robin merge of num_src AXI streams into one, bursts capped at max_burst,
// with one dead IDLE cycle per arbitration.
module axis_rr_arbiter #(
    parameter int num_src   = 4,
    parameter int bus_width = 256,
    parameter int max_burst = 16
) (
    input  logic                         axis_clk,
    input  logic                         rst,
    input  logic [num_src-1:0]           s_axis_tvalid,
    output logic [num_src-1:0]           s_axis_tready,
    input  logic [num_src*bus_width-1:0] s_axis_tdata,
    output logic [bus_width-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [$clog2(num_src)-1:0]   grant_id,
    output logic                         busy
);
    localparam int gw = $clog2(num_src);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [gw-1:0]  grant_q, grant_d, pick, idx;
    logic [7:0]     beat_q, beat_d;
    logic           xfer;

    assign busy          = state_q == GRANT;
    assign grant_id      = grant_q;
    assign m_axis_tvalid = busy && s_axis_tvalid[grant_q];
    assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*bus_width +: bus_width];
    assign s_axis_tready = (busy && m_axis_tready) ? {{(num_src-1){1'b0}}, 1'b1} << grant_q : '0;
    assign xfer          = m_axis_tvalid && m_axis_tready;

    // Scan downward so the nearest requester after the last grant overwrites the rest.
    always_comb begin
        pick = grant_q;
        idx  = grant_q;
        for (int k = num_src; k >= 1; k--) begin
            idx = gw'((int'(grant_q) + k) % num_src);
            if (s_axis_tvalid[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        if (state_q == IDLE) begin
            if (|s_axis_tvalid) begin
                state_d = GRANT;
                grant_d = pick;
                beat_d  = '0;
            end
        end else if (!s_axis_tvalid[grant_q]) begin
            state_d = IDLE;
        end else if (xfer) begin
            beat_d  = beat_q + 8'd1;
            state_d = (beat_d == 8'(max_burst)) ? IDLE : GRANT;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= gw'(num_src - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed and random checks of the round-robin AXI-stream arbiter.
module tb_axis_rr_arbiter;
    localparam int ns = 4;
    localparam int bw = 32;
    localparam int mb = 16;

    logic              axis_clk = 0;
    logic              rst = 0;
    logic [ns-1:0]     s_axis_tvalid = '0;
    logic [ns-1:0]     s_axis_tready;
    logic [ns*bw-1:0]  s_axis_tdata = '0;
    logic [bw-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 0;
    logic [1:0]        grant_id;
    logic              busy;

    axis_rr_arbiter #(.num_src(ns), .bus_width(bw), .max_burst(mb)) dut (
        .axis_clk(axis_clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 axis_clk = ~axis_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int left[ns];
    int seq[ns];
    int cur_id, cur_len, gap;
    logic busy_prev;
    int b_id[$];
    int b_len[$];
    int b_gap[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 0;
        s_axis_tvalid = '1;
        m_axis_tready = 1;
        repeat (2) @(posedge axis_clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, ns - 1);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_srdy", s_axis_tready, 0);
        rst = 1;
        for (int i = 0; i < ns; i++) begin
            left[i] = 0;
            seq[i]  = 0;
        end
        b_id.delete();
        b_len.delete();
        b_gap.delete();
        busy_prev = 0;
        gap = 0;
        cur_len = 0;
        cur_id = 0;
    endtask

    // One cycle: drive sources, sample outputs mid-cycle, then advance the source model past the edge.
    task automatic step(input logic rdy);
        logic x;
        m_axis_tready = rdy;
        for (int i = 0; i < ns; i++) begin
            s_axis_tvalid[i] = left[i] > 0;
            s_axis_tdata[i*bw +: bw] = {8'(i), 24'(seq[i])};
        end
        #1;
        if (busy && !busy_prev) begin
            cur_id = int'(grant_id);
            cur_len = 0;
            b_gap.push_back(gap);
        end
        if (!busy && busy_prev) begin
            b_id.push_back(cur_id);
            b_len.push_back(cur_len);
            chk("burst_max", cur_len >= 1 && cur_len <= mb, 1);
        end
        gap = busy ? 0 : gap + 1;
        busy_prev = busy;
        if (busy) begin
            chk("gid_stable", grant_id, cur_id);
            chk("mvalid", m_axis_tvalid, left[cur_id] > 0);
            chk("srdy", s_axis_tready, rdy ? (4'b0001 << cur_id) : 4'b0000);
            if (m_axis_tvalid) chk("data", m_axis_tdata, {8'(cur_id), 24'(seq[cur_id])});
        end else begin
            chk("idle_outs", {m_axis_tvalid, s_axis_tready}, 0);
        end
        x = m_axis_tvalid && m_axis_tready;
        @(posedge axis_clk);
        if (x) begin
            seq[cur_id]++;
            left[cur_id]--;
            cur_len++;
        end
        #1;
    endtask

    initial begin
        // single requester, 40 beats -> 16,16,8
        do_reset();
        left[0] = 40;
        repeat (50) step(1);
        chk("r20_nb", b_id.size(), 3);
        chk("r20_len0", b_len[0], 16);
        chk("r20_len1", b_len[1], 16);
        chk("r20_len2", b_len[2], 8);
        chk("r20_gap1", b_gap[1], 1);
        chk("r20_gap2", b_gap[2], 1);
        chk("r20_total", seq[0], 40);

        // all four valid -> 0,1,2,3,0 of 16 beats each
        do_reset();
        for (int i = 0; i < ns; i++) left[i] = 100;
        repeat (88) step(1);
        chk("r21_nb", b_id.size() >= 5, 1);
        chk("r21_id0", b_id[0], 0);
        chk("r21_id1", b_id[1], 1);
        chk("r21_id2", b_id[2], 2);
        chk("r21_id3", b_id[3], 3);
        chk("r21_id4", b_id[4], 0);
        for (int j = 0; j < 5; j++) chk("r21_len", b_len[j], 16);
        for (int j = 1; j < 5; j++) chk("r21_gap", b_gap[j], 1);

        // requester 2 with a 5-cycle downstream stall mid-burst
        do_reset();
        left[2] = 16;
        for (int c = 0; c < 30; c++) step(!(c >= 6 && c < 11));
        chk("r22_nb", b_id.size(), 1);
        chk("r22_id", b_id[0], 2);
        chk("r22_len", b_len[0], 16);
        chk("r22_total", seq[2], 16);

        // requester 1 drops after 3 beats, requester 3 waiting
        do_reset();
        left[1] = 3;
        left[3] = 50;
        repeat (25) step(1);
        chk("r23_id0", b_id[0], 1);
        chk("r23_len0", b_len[0], 3);
        chk("r23_id1", b_id[1], 3);
        chk("r23_gap1", b_gap[1], 1);

        // reset during beat 7
        do_reset();
        left[0] = 100;
        for (int c = 0; c < 30 && !(busy_prev && cur_len == 6); c++) step(1);
        chk("r24_reach", cur_len, 6);
        rst = 0;
        step(1);
        chk("r24_busy", busy, 0);
        chk("r24_srdy", s_axis_tready, 0);
        chk("r24_mvalid", m_axis_tvalid, 0);
        chk("r24_gid", grant_id, ns - 1);
        rst = 1;
        left[1] = 100;
        step(1);
        chk("r24_regrant_busy", busy, 1);
        chk("r24_regrant_gid", grant_id, 0);

        // random valid/ready soak
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < ns; i++)
                if (left[i] == 0 && $urandom_range(0, 7) == 0) left[i] = $urandom_range(1, 40);
            step($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 The block SHALL take parameter num_src, default 4, as the number of AXI-stream requesters (2..8).
REQ-002 The block SHALL take parameter bus_width, default 256, as the tdata width of every port.
REQ-003 The block SHALL take parameter max_burst, default 16, as the maximum beats per grant (1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset:
- axis_clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- s_axis_tvalid  in  num_src  per-requester valid.
- s_axis_tready  out  num_src  per-requester ready.
- s_axis_tdata  in  num_src*bus_width  requester i occupies bits [i*bus_width +: bus_width].
- m_axis_tdata  out  bus_width  merged stream data, toward the shared sync FIFO write port.
- m_axis_tvalid  out  1  merged stream valid.
- m_axis_tready  in  1  downstream ready (FIFO not full).
- grant_id  out  clog2(num_src)  index of the current or most recent grant.
- busy  out  1  high while in state GRANT.

Function
REQ-005 The block SHALL implement states IDLE and GRANT.
REQ-006 In IDLE, m_axis_tvalid and all s_axis_tready bits SHALL be 0.
REQ-007 In IDLE with any s_axis_tvalid high, the block SHALL select a requester on that edge and enter GRANT on the next cycle.
- Selection: round-robin, first requester with valid high, scanning from grant_id+1 upward with wrap at num_src-1 -> 0.
- Outputs: grant_id updates to the selected index; beat counter clears to 0.
REQ-008 In GRANT with granted index g, the merged stream SHALL be a pure combinational pass-through:
- m_axis_tvalid = s_axis_tvalid[g]; m_axis_tdata = s_axis_tdata[g].
- s_axis_tready[g] = m_axis_tready; all other s_axis_tready bits 0.
REQ-009 A beat SHALL transfer only on a cycle with m_axis_tvalid and m_axis_tready both high, and the beat counter SHALL increment by 1 on each transfer.
REQ-010 GRANT SHALL return to IDLE on the edge following either terminating condition:
- a transfer that makes the beat counter equal max_burst; or
- s_axis_tvalid[g] low in GRANT, where the granted requester is idle (no beat pending).
REQ-011 A stalled beat (tvalid high, m_axis_tready low) SHALL NOT end the grant, count a beat or change data; the block SHALL NOT drop or duplicate beats.
REQ-012 Every GRANT->IDLE transition SHALL insert exactly one IDLE cycle before the next grant (one dead cycle per arbitration).
REQ-013 With a single requester continuously valid and m_axis_tready high, that requester SHALL be re-granted after the dead cycle; the throughput is max_burst beats per max_burst+1 cycles.
REQ-014 Simultaneous requests SHALL be resolved by the round-robin pointer only; no requester SHALL wait more than num_src-1 grants.
REQ-015 Beat counter width SHALL be 8 bits; counter wrap SHALL NOT occur, because REQ-010 ends the grant first.
REQ-016 A requester deasserting tvalid while not granted SHALL have no effect.

Reset
REQ-017 While rst is low at a rising edge, the block SHALL apply these values on that edge:
- state = IDLE, beat counter = 0.
- grant_id = num_src-1, so that requester 0 wins first.
- busy = 0, m_axis_tvalid = 0, all s_axis_tready = 0.
REQ-018 Reset asserted mid-burst SHALL abort the grant on that edge, with no further beats transferred; the partially sent burst is not resumed.
REQ-019 Outputs SHALL be reset-independent of m_axis_tdata content; tdata is don't-care while m_axis_tvalid is 0.

Verification
REQ-020 Single requester: requester 0 valid continuously for 40 beats, m_axis_tready=1, max_burst=16 -> bursts of 16,16,8 beats with one dead cycle between them; data order preserved.
REQ-021 All four requesters valid continuously after reset -> grant_id sequence 0,1,2,3,0; each grant exactly 16 beats; busy low for one cycle between grants.
REQ-022 Requester 2 granted, m_axis_tready low for 5 cycles mid-burst -> s_axis_tready[2]=0, m_axis_tdata held stable, beat counter frozen; burst completes at 16 transfers.
REQ-023 Requester 1 granted, drops tvalid after 3 beats while requester 3 is valid -> return to IDLE, then grant_id=3 after one dead cycle.
REQ-024 rst driven low during beat 7 of a grant -> next cycle: IDLE, all readies 0, grant_id=num_src-1; after release, requester 0 is granted first if valid.
REQ-025 Random valid/ready stimulus, 10k cycles -> scoreboard shows no lost, duplicated or interleaved-within-burst beats, and no burst exceeds max_burst.
